spi_master_core: RTL
====================

// Module: spi_master_core
// PURPOSE
//  Parametrised SPI master shift engine: clock gen, shift regs, chip-select control in one block.
//  Sits between the register/AXI front end and the SPI pins; single sysclk domain.
//  Runtime char length 1..CHAR_NBITS_MAX, all 4 CPOL/CPHA modes, MSB/LSB-first, loopback, NUM_CS selects.
// PARAMETERS
//  N               8   width of divider_i; SCLK half-period = divider_i+1 sysclk cycles
//  CHAR_NBITS_MAX  32  max bits per char; LW = $clog2(CHAR_NBITS_MAX)
//  NUM_CS          4   number of active-low chip selects; CW = $clog2(NUM_CS) (min 1)
// PORTS
//  sysclk     in   1               system clock
//  rst        in   1               asynchronous reset, active-high
//  enable     in   1               block enable; low = abort/hold idle
//  go         in   1               start pulse; sampled only in IDLE
//  cpol       in   1               clock polarity
//  cpha       in   1               clock phase
//  lsb_first  in   1               1 = shift LSB first
//  loop       in   1               1 = rx samples mosi internally, miso ignored
//  char_len   in   LW              bits per char minus 1 (0 -> 1 bit)
//  divider_i  in   N               clock divider
//  cs_sel     in   CW              chip select index
//  tx_data    in   CHAR_NBITS_MAX  tx char, right-aligned
//  rx_data    out  CHAR_NBITS_MAX  rx char, right-aligned, upper bits 0
//  busy       out  1               transfer in progress
//  done       out  1               1-cycle pulse at end of complete transfer
//  sclk       out  1               SPI clock
//  mosi       out  1               master out
//  miso       in   1               master in
//  cs_n       out  NUM_CS          chip selects, active-low
// BEHAVIOUR
//  Reset (async, rst=1): state IDLE; sclk=0, mosi=0, cs_n=all 1, busy=0, done=0, rx_data=0.
//  Config latch: on go&enable in IDLE, capture cpol,cpha,lsb_first,loop,char_len(L-1),
//   divider_i(D),cs_sel,tx_data; later input changes ignored until next IDLE.
//  IDLE: sclk <= cpol (registered, tracks input); cs_n all 1; go ignored while enable=0.
//  FSM IDLE->LEAD->XFER->TRAIL->IDLE; each phase timed by half-period counter of D+1 cycles.
//   LEAD: 1 half-period; selected cs_n low, others high; sclk idle; first bit on mosi.
//   XFER: 2*L half-periods; sclk toggles at each half-period end (L full cycles).
//    CPHA=0: sample on leading edge, shift mosi on trailing edge (no shift after last).
//    CPHA=1: shift mosi on leading edge (first bit driven here), sample on trailing edge.
//   TRAIL: 1 half-period; sclk idle; cs_n still low.
//   Exit: cs_n all 1, busy 0, done=1 for one cycle, rx_data updated same cycle.
//  Timing: go at cycle 0 -> busy=1 from cycle 1 for exactly (2L+2)*(D+1) cycles.
//  Bit order: lsb_first=0 sends tx_data[L-1] first; lsb_first=1 sends tx_data[0] first.
//   rx assembled in same order; rx_data[L-1:0] valid, [MAX-1:L]=0.
//  rx_data holds last completed value until next completed transfer.
//  go while busy: ignored. go & enable same cycle from IDLE: starts.
//  enable low mid-transfer: next cycle IDLE, cs_n all 1, sclk=cpol, no done, rx_data unchanged.
//  rst mid-transfer: immediate reset values, no done.
//  D=0: half-period 1 cycle (sclk = sysclk/2). cs_sel >= NUM_CS: no cs_n asserted, shift still runs.
// TESTING
//  1 Mode3, loop=1, L=8, D=4, tx=0x5A, cs_sel=0 -> sclk period 10 cycles, 8 edges pairs,
//    busy 90 cycles, done pulse, rx_data=0x0000005A, cs_n=4'b1110 during busy.
//  2 All 4 modes, loop=0, miso from bench slave model returning 0xA5, L=8 -> rx_data=0xA5,
//    mosi bits match 0x3C MSB-first, sclk idles at cpol.
//  3 lsb_first=1, L=32, D=0, tx=0x80000001, loop=1 -> rx=0x80000001, busy 66 cycles, first mosi bit 1.
//  4 L=1 (char_len=0), tx=1 -> exactly one sclk cycle, rx_data=0x1; L=12 tx=0xFFF -> rx=0x00000FFF.
//  5 enable dropped at cycle 30 of mode0 transfer -> cs_n=all 1 next cycle, no done,
//    rx_data keeps previous value; new go afterwards completes normally.
//  6 go pulsed again mid-transfer, rst asserted mid-transfer -> second go ignored;
//    rst forces reset values immediately, no done.

Source files
------------

// File: rtl/spi_master_core.sv
// SPI master shift engine: SCLK generation, tx/rx shifting and chip-select control.
// Every output is registered; configuration is captured when a transfer starts.
module spi_master_core #(
  parameter int N              = 8,
  parameter int CHAR_NBITS_MAX = 32,
  parameter int NUM_CS         = 4,
  localparam int LW = $clog2(CHAR_NBITS_MAX),
  localparam int CW = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic                      sysclk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      go,
  input  logic                      cpol,
  input  logic                      cpha,
  input  logic                      lsb_first,
  input  logic                      loop,
  input  logic [LW-1:0]             char_len,
  input  logic [N-1:0]              divider_i,
  input  logic [CW-1:0]             cs_sel,
  input  logic [CHAR_NBITS_MAX-1:0] tx_data,
  output logic [CHAR_NBITS_MAX-1:0] rx_data,
  output logic                      busy,
  output logic                      done,
  output logic                      sclk,
  output logic                      mosi,
  input  logic                      miso,
  output logic [NUM_CS-1:0]         cs_n
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LEAD  = 2'd1,
    S_XFER  = 2'd2,
    S_TRAIL = 2'd3
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [N-1:0]              r_cnt;
  logic [LW:0]               r_hcnt;
  logic                      r_cpol;
  logic                      r_cpha;
  logic                      r_lsb;
  logic                      r_loop;
  logic [LW-1:0]             r_len;
  logic [N-1:0]              r_div;
  logic [CHAR_NBITS_MAX-1:0] r_tx;
  logic [CHAR_NBITS_MAX-1:0] r_rx;
  logic [CHAR_NBITS_MAX-1:0] r_rx_data;
  logic                      r_sclk;
  logic                      r_mosi;
  logic                      r_busy;
  logic                      r_done;
  logic [NUM_CS-1:0]         r_cs_n;

  logic                      w_start;
  logic                      w_finish;
  logic                      w_hp_end;
  logic                      w_last_hp;
  logic                      w_xfer_edge;
  logic                      w_lead_edge;
  logic                      w_trail_edge;
  logic [LW-1:0]             w_bit_num;
  logic                      w_last_bit;
  logic                      w_sample;
  logic                      w_do_sample;
  logic                      w_do_drive;
  logic [LW-1:0]             w_rx_idx;
  logic [LW-1:0]             w_tx_idx;

  // Position of the num-th transmitted bit inside the right-aligned character.
  function automatic logic [LW-1:0] f_bit_pos(input logic lsb, input logic [LW-1:0] len,
                                              input logic [LW-1:0] num);
    if (lsb) begin
      f_bit_pos = num;
    end else begin
      f_bit_pos = len - num;
    end
  endfunction

  // Out-of-range select indices leave every chip select deasserted.
  function automatic logic [NUM_CS-1:0] f_cs_decode(input logic [CW-1:0] sel);
    for (int i = 0; i < NUM_CS; i++) begin
      if (sel == CW'(i)) begin
        f_cs_decode[i] = 1'b0;
      end else begin
        f_cs_decode[i] = 1'b1;
      end
    end
  endfunction

  assign w_hp_end     = (r_cnt == r_div);
  assign w_last_hp    = (r_hcnt == {r_len, 1'b1});
  assign w_xfer_edge  = (r_state == S_XFER) && w_hp_end;
  assign w_lead_edge  = w_xfer_edge && !r_hcnt[0];
  assign w_trail_edge = w_xfer_edge && r_hcnt[0];
  assign w_bit_num    = r_hcnt[LW:1];
  assign w_last_bit   = (w_bit_num == r_len);
  assign w_sample     = r_loop ? r_mosi : miso;
  assign w_do_sample  = r_cpha ? w_trail_edge : w_lead_edge;
  assign w_do_drive   = r_cpha ? w_lead_edge : (w_trail_edge && !w_last_bit);
  assign w_rx_idx     = f_bit_pos(r_lsb, r_len, w_bit_num);
  assign w_tx_idx     = r_cpha ? f_bit_pos(r_lsb, r_len, w_bit_num)
                               : f_bit_pos(r_lsb, r_len, w_bit_num + {{(LW-1){1'b0}}, 1'b1});

  // Next-state logic; dropping enable returns to IDLE from any state.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_finish    = 1'b0;
    if (!enable) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (go) begin
            w_state_nxt = S_LEAD;
            w_start     = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_LEAD: begin
          if (w_hp_end) begin
            w_state_nxt = S_XFER;
          end else begin
            w_state_nxt = S_LEAD;
          end
        end
        S_XFER: begin
          if (w_hp_end && w_last_hp) begin
            w_state_nxt = S_TRAIL;
          end else begin
            w_state_nxt = S_XFER;
          end
        end
        S_TRAIL: begin
          if (w_hp_end) begin
            w_state_nxt = S_IDLE;
            w_finish    = 1'b1;
          end else begin
            w_state_nxt = S_TRAIL;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath: config capture, half-period timing, shifting and pin drive.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      r_cnt     <= {N{1'b0}};
      r_hcnt    <= {(LW+1){1'b0}};
      r_cpol    <= 1'b0;
      r_cpha    <= 1'b0;
      r_lsb     <= 1'b0;
      r_loop    <= 1'b0;
      r_len     <= {LW{1'b0}};
      r_div     <= {N{1'b0}};
      r_tx      <= {CHAR_NBITS_MAX{1'b0}};
      r_rx      <= {CHAR_NBITS_MAX{1'b0}};
      r_rx_data <= {CHAR_NBITS_MAX{1'b0}};
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_cs_n    <= {NUM_CS{1'b1}};
    end else begin
      r_done <= 1'b0;
      if (w_start) begin
        r_cpol <= cpol;
        r_cpha <= cpha;
        r_lsb  <= lsb_first;
        r_loop <= loop;
        r_len  <= char_len;
        r_div  <= divider_i;
        r_tx   <= tx_data;
        r_rx   <= {CHAR_NBITS_MAX{1'b0}};
        r_cnt  <= {N{1'b0}};
        r_hcnt <= {(LW+1){1'b0}};
        r_busy <= 1'b1;
        r_sclk <= cpol;
        r_mosi <= tx_data[f_bit_pos(lsb_first, char_len, {LW{1'b0}})];
        r_cs_n <= f_cs_decode(cs_sel);
      end else if ((r_state == S_IDLE) || !enable) begin
        r_cnt  <= {N{1'b0}};
        r_busy <= 1'b0;
        r_sclk <= cpol;
        r_mosi <= 1'b0;
        r_cs_n <= {NUM_CS{1'b1}};
      end else begin
        if (w_hp_end) begin
          r_cnt <= {N{1'b0}};
        end else begin
          r_cnt <= r_cnt + {{(N-1){1'b0}}, 1'b1};
        end
        if (w_xfer_edge) begin
          r_sclk <= ~r_sclk;
          r_hcnt <= r_hcnt + {{LW{1'b0}}, 1'b1};
        end
        if (w_do_sample) begin
          r_rx[w_rx_idx] <= w_sample;
        end
        if (w_do_drive) begin
          r_mosi <= r_tx[w_tx_idx];
        end
        // rx_data only moves on a completed transfer, never on an abort.
        if (w_finish) begin
          r_busy    <= 1'b0;
          r_done    <= 1'b1;
          r_rx_data <= r_rx;
          r_cs_n    <= {NUM_CS{1'b1}};
          r_sclk    <= r_cpol;
          r_mosi    <= 1'b0;
        end
      end
    end
  end

  assign rx_data = r_rx_data;
  assign busy    = r_busy;
  assign done    = r_done;
  assign sclk    = r_sclk;
  assign mosi    = r_mosi;
  assign cs_n    = r_cs_n;

endmodule
